insn_fetch_queue: RTL and testbench

//  Prefetching instruction fetch stage between TachyonCore's fetch port and the SimRAM read port.

---
 rtl/insn_fetch_queue_if.sv | 23 ++
 rtl/insn_fetch_queue.sv | 81 ++++++++
 tb/tb_insn_fetch_queue.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/insn_fetch_queue_if.sv
// rtl/insn_fetch_queue_if.sv - fetch-stream and RAM read-port bundle for insn_fetch_queue
interface insn_fetch_queue_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int INSN_WIDTH = 32
);
  logic                  insn_valid;
  logic                  insn_ready;
  logic [INSN_WIDTH-1:0] insn_data;
  logic [ADDR_WIDTH-3:0] insn_addr;
  logic                  ram_rd_en;
  logic [ADDR_WIDTH-3:0] ram_rd_addr;
  logic [INSN_WIDTH-1:0] ram_rd_data;

  modport master (
    output insn_valid, insn_data, insn_addr, ram_rd_en, ram_rd_addr,
    input  insn_ready, ram_rd_data
  );

  modport slave (
    input  insn_valid, insn_data, insn_addr, ram_rd_en, ram_rd_addr,
    output insn_ready, ram_rd_data
  );
endinterface

// File: rtl/insn_fetch_queue.sv
// rtl/insn_fetch_queue.sv - prefetching instruction fetch queue between core and SimRAM
// Reads run ahead of the core; each returned word is stored with its word address.
module insn_fetch_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int INSN_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_WIDTH-3:0]        rst_addr,
  input  logic                         halt,
  input  logic                         redirect_en,
  input  logic [ADDR_WIDTH-3:0]        redirect_addr,
  output logic [$clog2(DEPTH+1)-1:0]   fill_level,
  insn_fetch_queue_if.master           bus
);
  localparam int WA = ADDR_WIDTH - 2;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WA-1:0]         fetch_pc;
  logic [CW-1:0]         count;
  logic                  inflight;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [INSN_WIDTH-1:0] data_mem [DEPTH];
  logic [WA-1:0]         addr_mem [DEPTH];
  logic [CW:0]           credit_used;
  logic                  issue;
  logic                  push;
  logic                  pop;

  // A read in flight already owns a slot, so it counts against the credit.
  assign credit_used = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign issue       = !rst && !halt && !redirect_en && (credit_used < (CW+1)'(DEPTH));
  assign push        = inflight && !redirect_en;
  assign pop         = bus.insn_valid && bus.insn_ready;

  assign bus.ram_rd_en   = issue;
  assign bus.ram_rd_addr = fetch_pc;
  assign bus.insn_valid  = !rst && !redirect_en && (count != '0);
  assign bus.insn_data   = data_mem[rd_ptr];
  assign bus.insn_addr   = addr_mem[rd_ptr];
  assign fill_level      = rst ? '0 : count;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= rst_addr;
      count    <= '0;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else if (redirect_en) begin
      fetch_pc <= redirect_addr;
      count    <= '0;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      inflight <= issue;
      if (issue)
        fetch_pc <= fetch_pc + WA'(1);
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
    end
  end

  // fetch_pc has already advanced past the returning read, hence the -1.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      data_mem[wr_ptr] <= bus.ram_rd_data;
      addr_mem[wr_ptr] <= fetch_pc - WA'(1);
    end
  end
endmodule

// File: tb/tb_insn_fetch_queue.sv
// tb/tb_insn_fetch_queue.sv - self-checking bench for insn_fetch_queue
module tb_insn_fetch_queue;
  localparam int AW    = 32;
  localparam int IW    = 32;
  localparam int DEPTH = 4;
  localparam int WA    = AW - 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst;
  logic          halt;
  logic          redirect_en;
  logic [WA-1:0] rst_addr;
  logic [WA-1:0] redirect_addr;
  logic [CW-1:0] fill_level;
  logic [IW-1:0] salt;

  int errors = 0;
  int checks = 0;
  int nreads;

  insn_fetch_queue_if #(.ADDR_WIDTH(AW), .INSN_WIDTH(IW)) bus ();

  insn_fetch_queue #(.ADDR_WIDTH(AW), .INSN_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .rst_addr     (rst_addr),
    .halt         (halt),
    .redirect_en  (redirect_en),
    .redirect_addr(redirect_addr),
    .fill_level   (fill_level),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [IW-1:0] ram_fn(input logic [WA-1:0] a);
    return {2'b00, a} ^ salt;
  endfunction

  // RAM returns garbage on cycles without a read so stale data cannot pass unnoticed.
  always @(posedge clk)
    bus.ram_rd_data <= bus.ram_rd_en ? ram_fn(bus.ram_rd_addr) : $urandom;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [WA-1:0] a;
    logic [IW-1:0] d;
  } ent_t;

  ent_t          m_fifo[$];
  ent_t          m_pend[$];
  logic [WA-1:0] m_pc;

  // Reference model: a queue of delivered-to-be words plus a queue of reads on the bus.
  task automatic advance();
    bit   e_valid;
    bit   e_en;
    int   e_fill;
    ent_t e;
    #1;
    e_valid = !rst && !redirect_en && (m_fifo.size() != 0);
    e_fill  = rst ? 0 : m_fifo.size();
    e_en    = !rst && !halt && !redirect_en && (m_fifo.size() + m_pend.size() < DEPTH);
    chk("m_valid", bus.insn_valid, e_valid);
    chk("m_fill", fill_level, e_fill);
    chk("m_rd_en", bus.ram_rd_en, e_en);
    if (e_en && bus.ram_rd_en)
      chk("m_rd_addr", bus.ram_rd_addr, m_pc);
    if (e_valid && bus.insn_valid) begin
      chk("m_insn_addr", bus.insn_addr, m_fifo[0].a);
      chk("m_insn_data", bus.insn_data, m_fifo[0].d);
    end
    if (rst) begin
      m_fifo.delete();
      m_pend.delete();
      m_pc = rst_addr;
    end else if (redirect_en) begin
      m_fifo.delete();
      m_pend.delete();
      m_pc = redirect_addr;
    end else begin
      if (e_valid && bus.insn_ready)
        void'(m_fifo.pop_front());
      if (m_pend.size() != 0)
        m_fifo.push_back(m_pend.pop_front());
      if (e_en) begin
        e.a = m_pc;
        e.d = ram_fn(m_pc);
        m_pend.push_back(e);
        m_pc = m_pc + WA'(1);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit r, input bit h, input bit d, input logic [WA-1:0] ra, input bit rd);
    rst              = r;
    halt             = h;
    redirect_en      = d;
    redirect_addr    = ra;
    bus.insn_ready   = rd;
  endtask

  typedef struct {
    bit            rst;
    bit            halt;
    bit            redir;
    logic [WA-1:0] raddr;
    bit            ready;
    bit            ev;
    logic [WA-1:0] ea;
    int            ef;
    bit            ee;
    logic [WA-1:0] eaddr;
  } vec_t;

  vec_t tv[$];

  function automatic void addv(input bit r, input bit h, input bit d, input logic [WA-1:0] ra,
                               input bit rd, input bit ev, input logic [WA-1:0] ea, input int ef,
                               input bit ee, input logic [WA-1:0] eaddr);
    vec_t v;
    v.rst = r; v.halt = h; v.redir = d; v.raddr = ra; v.ready = rd;
    v.ev = ev; v.ea = ea; v.ef = ef; v.ee = ee; v.eaddr = eaddr;
    tv.push_back(v);
  endfunction

  logic [WA-1:0] exp_wrap [3];

  initial begin
    rst_addr = 'h100;
    salt     = '0;
    drive(1, 0, 0, '0, 1);

    //   rst h  d  raddr    rdy  ev ea       ef ee eaddr
    addv(1, 0, 0, 'h0,    1,   0, 'h0,    0, 0, 'h0);
    addv(0, 0, 0, 'h0,    1,   0, 'h0,    0, 1, 'h100);
    addv(0, 0, 0, 'h0,    1,   0, 'h0,    0, 1, 'h101);
    addv(0, 0, 0, 'h0,    1,   1, 'h100,  1, 1, 'h102);
    addv(0, 0, 0, 'h0,    1,   1, 'h101,  1, 1, 'h103);
    addv(0, 0, 0, 'h0,    0,   1, 'h102,  1, 1, 'h104);
    addv(0, 0, 0, 'h0,    0,   1, 'h102,  2, 1, 'h105);
    addv(0, 0, 0, 'h0,    0,   1, 'h102,  3, 0, 'h0);
    addv(0, 0, 0, 'h0,    0,   1, 'h102,  4, 0, 'h0);
    addv(0, 0, 0, 'h0,    1,   1, 'h102,  4, 0, 'h0);
    addv(0, 0, 0, 'h0,    0,   1, 'h103,  3, 1, 'h106);
    addv(0, 0, 1, 'h2000, 0,   0, 'h0,    3, 0, 'h0);
    addv(0, 0, 0, 'h0,    1,   0, 'h0,    0, 1, 'h2000);
    addv(0, 0, 0, 'h0,    1,   0, 'h0,    0, 1, 'h2001);
    addv(0, 0, 0, 'h0,    1,   1, 'h2000, 1, 1, 'h2002);
    addv(0, 1, 0, 'h0,    1,   1, 'h2001, 1, 0, 'h0);
    addv(0, 1, 0, 'h0,    1,   1, 'h2002, 1, 0, 'h0);
    addv(0, 1, 0, 'h0,    1,   0, 'h0,    0, 0, 'h0);
    addv(0, 0, 0, 'h0,    1,   0, 'h0,    0, 1, 'h2003);
    addv(0, 0, 0, 'h0,    1,   0, 'h0,    0, 1, 'h2004);
    addv(0, 0, 0, 'h0,    1,   1, 'h2003, 1, 1, 'h2005);
    addv(0, 1, 1, 'h3000, 1,   0, 'h0,    1, 0, 'h0);
    addv(0, 1, 0, 'h0,    1,   0, 'h0,    0, 0, 'h0);
    addv(0, 0, 0, 'h0,    1,   0, 'h0,    0, 1, 'h3000);
    addv(0, 0, 0, 'h0,    1,   0, 'h0,    0, 1, 'h3001);
    addv(0, 0, 0, 'h0,    1,   1, 'h3000, 1, 1, 'h3002);

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].rst, tv[i].halt, tv[i].redir, tv[i].raddr, tv[i].ready);
      #1;
      chk($sformatf("tv%0d_valid", i), bus.insn_valid, tv[i].ev);
      chk($sformatf("tv%0d_fill", i), fill_level, tv[i].ef);
      chk($sformatf("tv%0d_rd_en", i), bus.ram_rd_en, tv[i].ee);
      if (tv[i].ev) begin
        chk($sformatf("tv%0d_addr", i), bus.insn_addr, tv[i].ea);
        chk($sformatf("tv%0d_data", i), bus.insn_data, {2'b00, tv[i].ea});
      end
      if (tv[i].ee)
        chk($sformatf("tv%0d_rd_addr", i), bus.ram_rd_addr, tv[i].eaddr);
      advance();
    end

    // Stall from reset, then reset with the queue full.
    salt     = 32'h5A5A_0000;
    rst_addr = 'h100;
    drive(1, 0, 0, '0, 0);
    advance();
    nreads = 0;
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, '0, 0);
      #1;
      if (bus.ram_rd_en) nreads++;
      advance();
    end
    chk("t2_reads", nreads, 4);
    #1;
    chk("t2_full", fill_level, 4);
    chk("t2_rd_en_full", bus.ram_rd_en, 0);
    advance();
    drive(0, 0, 0, '0, 1);
    #1;
    chk("t2_pop_valid", bus.insn_valid, 1);
    chk("t2_pop_addr", bus.insn_addr, 'h100);
    advance();
    drive(0, 0, 0, '0, 0);
    #1;
    chk("t2_next_en", bus.ram_rd_en, 1);
    chk("t2_next_addr", bus.ram_rd_addr, 'h104);
    advance();
    advance();
    #1;
    chk("t6_full", fill_level, 4);
    rst_addr = 'h55;
    drive(1, 0, 0, '0, 0);
    #1;
    chk("t6_rst_fill", fill_level, 0);
    chk("t6_rst_valid", bus.insn_valid, 0);
    chk("t6_rst_rd_en", bus.ram_rd_en, 0);
    advance();
    drive(0, 0, 0, '0, 1);
    #1;
    chk("t6_restart_en", bus.ram_rd_en, 1);
    chk("t6_restart_addr", bus.ram_rd_addr, 'h55);
    chk("t6_after_fill", fill_level, 0);
    chk("t6_after_valid", bus.insn_valid, 0);
    advance();
    #1;
    chk("t6_second_addr", bus.ram_rd_addr, 'h56);
    chk("t6_second_valid", bus.insn_valid, 0);
    advance();
    #1;
    chk("t6_first_valid", bus.insn_valid, 1);
    chk("t6_first_addr", bus.insn_addr, 'h55);
    chk("t6_first_data", bus.insn_data, {2'b00, 30'h55} ^ salt);
    advance();

    // Word-address wrap.
    salt        = 32'h0F0F_F0F0;
    rst_addr    = 30'h3FFF_FFFF;
    exp_wrap[0] = 30'h3FFF_FFFF;
    exp_wrap[1] = 30'h0;
    exp_wrap[2] = 30'h1;
    drive(1, 0, 0, '0, 1);
    advance();
    drive(0, 0, 0, '0, 1);
    advance();
    advance();
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("t5_valid%0d", k), bus.insn_valid, 1);
      chk($sformatf("t5_addr%0d", k), bus.insn_addr, exp_wrap[k]);
      chk($sformatf("t5_data%0d", k), bus.insn_data, {2'b00, exp_wrap[k]} ^ salt);
      advance();
    end

    // Random traffic against the model.
    salt     = $urandom;
    rst_addr = WA'($urandom);
    drive(1, 0, 0, '0, 1);
    advance();
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 199) == 0,
            $urandom_range(0, 99) < 10,
            $urandom_range(0, 99) < 3,
            WA'($urandom),
            $urandom_range(0, 99) < 60);
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
